serial_ripple_subtractor: RTL and testbench
===========================================

# serial_ripple_subtractor

Bit-serial subtractor computing diff = a − b − bin over WIDTH bits, processing one bit per clock LSB-first through a single full-subtractor cell with a registered borrow. It is the inverse counterpart of the structural ripple adder: same operand/carry-style interface, but with subtraction and borrow in place of addition and carry. It trades latency for area and uses a start/busy/done handshake so a controller can issue operations.

## Interface
- WIDTH, 4, operand and result width in bits (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only on an edge where busy=0
- a  input  WIDTH  minuend, sampled on the accepting edge only
- b  input  WIDTH  subtrahend, sampled on the accepting edge only
- bin  input  1  borrow-in, sampled on the accepting edge only
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse: diff/bout updated this cycle
- diff  output  WIDTH  result register, (a − b − bin) mod 2^WIDTH
- bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)

## Operation
- Internal state: FSM {IDLE, RUN}, shift registers a_sh/b_sh/d_sh (WIDTH), borrow register brw, bit counter cnt (clog2(WIDTH) bits).
- IDLE: on edge with start=1 → load a_sh=a, b_sh=b, brw=bin, cnt=0, d_sh=0; go RUN; busy←1.
- RUN, each edge: x=a_sh[0], y=b_sh[0];
  - d = x ^ y ^ brw; shift d into d_sh at MSB (d_sh >> 1).
  - brw ← (~x & y) | (~(x ^ y) & brw).
  - a_sh, b_sh shift right by 1; cnt ← cnt+1.
  - On the edge where cnt = WIDTH−1 (last bit): diff ← final shifted value including d; bout ← new borrow; done←1; busy←0; go IDLE.
- done deasserts on the next edge unless that edge completes another operation.
- diff and bout change only on completion edges; held stable otherwise (including through a new operation).
- start while busy=1: ignored, no effect on the running operation, not queued.
- start on the same edge done is high (busy=0): accepted; done clears next edge, diff/bout keep the previous result until the new operation completes.
- Operand inputs are don't-care except on the accepting edge.

## Timing
- Reset (async assert, any time): state IDLE, busy=0, done=0, diff=0, bout=0, brw=0, cnt=0, shift registers 0. Output change does not wait for a clock edge.
- Reset mid-operation aborts; no done pulse; diff/bout read 0 afterwards.
- Deassertion is taken synchronous to clk by the surrounding reset logic; first accepting edge is the first rising edge after rst_n high.
- Accepting edge E: busy=1 after E; processing edges E+1 … E+WIDTH; after E+WIDTH busy=0, done=1, diff/bout valid. Latency start-sample → done = WIDTH clocks.
- Throughput: one operation per WIDTH+1 clocks sustained (start held high continuously gives one accept every WIDTH+1 edges... accept at E, next accept at E+WIDTH+1? no: accept at E+WIDTH+1 is the edge where done=1 and busy=0), i.e. back-to-back with no idle cycle beyond the done cycle.
- All outputs registered; no combinational path from inputs to outputs.

## Test plan
- Reset: rst_n=0 mid-run (2 edges after start with WIDTH=4) → busy, done, diff, bout all 0 immediately; no done pulse ever follows.
- WIDTH=4, a=9, b=3, bin=0 → busy high 4 clocks, done pulse with diff=6, bout=0; a=3, b=9, bin=0 → diff=4'hA, bout=1.
- Boundary: a=0, b=0, bin=1 → diff=4'hF, bout=1; a=F, b=F, bin=1 → diff=F, bout=1; a=F, b=0, bin=0 → diff=F, bout=0.
- start pulsed with a=1,b=1 while busy (operation a=7,b=2 in flight) → result diff=5, bout=0; no second done.
- start held high continuously with changing operands → accepts exactly at each done cycle, one done per WIDTH+1 clocks, diff stable between done pulses.
- Exhaustive WIDTH=4 (all 512 a/b/bin combos) and random WIDTH=16 → {bout,diff} equals (a − b − bin) as WIDTH+1-bit two's complement at every done.

Source files
------------

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH bits, one bit per clock LSB-first.
// A single full-subtractor cell feeds a registered borrow; start/busy/done handshake.
module serial_ripple_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             dbg_state_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] d_sh_q, d_sh_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Full-subtractor cell on the current LSBs.
  logic x, y, d_bit, brw_next;
  assign x        = a_sh_q[0];
  assign y        = b_sh_q[0];
  assign d_bit    = x ^ y ^ brw_q;
  assign brw_next = (~x & y) | (~(x ^ y) & brw_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    d_sh_d  = d_sh_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          brw_d   = bin;
          d_sh_d  = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        d_sh_d = {d_bit, d_sh_q[WIDTH-1:1]};
        brw_d  = brw_next;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          // Result registers only move on completion, so they hold through a new run.
          diff_d  = {d_bit, d_sh_q[WIDTH-1:1]};
          bout_d  = brw_next;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      d_sh_q  <= d_sh_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign diff        = diff_q;
  assign bout        = bout_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Bench for serial_ripple_subtractor: WIDTH=4 (directed + exhaustive) and WIDTH=16 (random)
// instances; expected {bout,diff} values are queued at accept and checked at each done.
module tb_serial_ripple_subtractor;

  logic        clk;
  logic        rst_n;

  logic        start4, bin4, busy4, done4, bout4, st4;
  logic [3:0]  a4, b4, diff4;
  logic        start16, bin16, busy16, done16, bout16, st16;
  logic [15:0] a16, b16, diff16;

  logic [4:0]  exp4_q[$];
  logic [16:0] exp16_q[$];

  int checks = 0;
  int errors = 0;

  serial_ripple_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4), .dbg_state_o(st4)
  );

  serial_ripple_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .bout(bout16), .dbg_state_o(st16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst_n && done4) begin
      checks++;
      if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL w4_unexpected_done got=%h", {bout4, diff4});
      end else begin
        logic [4:0] e;
        e = exp4_q.pop_front();
        if ({bout4, diff4} !== e) begin
          errors++;
          $display("FAIL w4_result got bout=%b diff=%h exp bout=%b diff=%h", bout4, diff4, e[4], e[3:0]);
        end
      end
    end
    if (rst_n && done16) begin
      checks++;
      if (exp16_q.size() == 0) begin
        errors++;
        $display("FAIL w16_unexpected_done got=%h", {bout16, diff16});
      end else begin
        logic [16:0] e;
        e = exp16_q.pop_front();
        if ({bout16, diff16} !== e) begin
          errors++;
          $display("FAIL w16_result got bout=%b diff=%h exp bout=%b diff=%h", bout16, diff16, e[16], e[15:0]);
        end
      end
    end
  end

  function automatic logic [4:0] ref4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {4'd0, bi};
  endfunction

  function automatic logic [16:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {16'd0, bi};
  endfunction

  // driver tasks
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    int t;
    t = 0;
    while (busy4 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (busy4) begin
      errors++;
      $display("FAIL w4_idle_timeout busy=%b exp=0", busy4);
    end
    start4 = 1'b1; a4 = a; b4 = b; bin4 = bi;
    @(posedge clk);
    exp4_q.push_back(ref4(a, b, bi));
    #1 start4 = 1'b0;
    a4 = 4'($urandom_range(0, 15)); b4 = 4'($urandom_range(0, 15));
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      checks++;
      if (k < 4 && (busy4 !== 1'b1 || done4 !== 1'b0)) begin
        errors++;
        $display("FAIL w4_latency k=%0d busy=%b done=%b exp busy=1 done=0", k, busy4, done4);
      end else if (k == 4 && (busy4 !== 1'b0 || done4 !== 1'b1)) begin
        errors++;
        $display("FAIL w4_done_edge busy=%b done=%b exp busy=0 done=1", busy4, done4);
      end
    end
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi);
    int t;
    start16 = 1'b1; a16 = a; b16 = b; bin16 = bi;
    @(posedge clk);
    exp16_q.push_back(ref16(a, b, bi));
    #1 start16 = 1'b0;
    t = 0;
    while (!done16 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (!done16 || t != 16) begin
      errors++;
      $display("FAIL w16_latency cycles=%0d done=%b exp cycles=16 done=1", t, done16);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++;
    if ({busy4, done4, bout4, diff4} !== 7'd0 || {busy16, done16, bout16, diff16} !== 19'd0) begin
      errors++;
      $display("FAIL reset_state w4=%b_%b_%b_%h w16=%b_%b_%b_%h exp all 0",
               busy4, done4, bout4, diff4, busy16, done16, bout16, diff16);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_basic();
    op4(4'd9, 4'd3, 1'b0);
    op4(4'd3, 4'd9, 1'b0);
  endtask

  task automatic test_boundary();
    op4(4'h0, 4'h0, 1'b1);
    op4(4'hF, 4'hF, 1'b1);
    op4(4'hF, 4'h0, 1'b0);
  endtask

  task automatic test_reset_mid_run();
    op4(4'd9, 4'd3, 1'b0);
    start4 = 1'b1; a4 = 4'd3; b4 = 4'd9; bin4 = 1'b0;
    @(posedge clk); #1 start4 = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, bout4, diff4} !== 7'd0) begin
      errors++;
      $display("FAIL reset_mid_run busy=%b done=%b bout=%b diff=%h exp all 0", busy4, done4, bout4, diff4);
    end
    exp4_q.delete();
    exp16_q.delete();
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (done4 !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_done done=%b exp 0", done4);
      end
    end
  endtask

  task automatic test_start_while_busy();
    start4 = 1'b1; a4 = 4'd7; b4 = 4'd2; bin4 = 1'b0;
    @(posedge clk);
    exp4_q.push_back(ref4(4'd7, 4'd2, 1'b0));
    #1 start4 = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        start4 = 1'b1; a4 = 4'd1; b4 = 4'd1;
      end else if (k == 2) begin
        start4 = 1'b0;
      end
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0) begin
        errors++;
        $display("FAIL busy_start_queued busy=%b exp 0", busy4);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] na, nb;
    logic       nbi;
    logic [3:0] prev_diff;
    na = 4'd12; nb = 4'd5; nbi = 1'b1;
    prev_diff = 4'd0;
    start4 = 1'b1; a4 = na; b4 = nb; bin4 = nbi;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      exp4_q.push_back(ref4(na, nb, nbi));
      #1;
      na = 4'($urandom_range(0, 15)); nb = 4'($urandom_range(0, 15)); nbi = 1'($urandom_range(0, 1));
      a4 = na; b4 = nb; bin4 = nbi;
      checks++;
      if (busy4 !== 1'b1 || done4 !== 1'b0 || (i > 0 && diff4 !== prev_diff)) begin
        errors++;
        $display("FAIL b2b_accept i=%0d busy=%b done=%b diff=%h exp busy=1 done=0 diff=%h", i, busy4, done4, diff4, prev_diff);
      end
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk); #1;
        checks++;
        if (k < 4 && (busy4 !== 1'b1 || (i > 0 && diff4 !== prev_diff))) begin
          errors++;
          $display("FAIL b2b_stable i=%0d k=%0d busy=%b diff=%h exp busy=1 diff=%h", i, k, busy4, diff4, prev_diff);
        end else if (k == 4 && (done4 !== 1'b1 || busy4 !== 1'b0)) begin
          errors++;
          $display("FAIL b2b_done i=%0d done=%b busy=%b exp done=1 busy=0", i, done4, busy4);
        end
      end
      prev_diff = exp4_q[exp4_q.size() - 1][3:0];
      if (i == 5) start4 = 1'b0;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_exhaustive4();
    for (int v = 0; v < 512; v++) begin
      logic [8:0] vv;
      vv = 9'(v);
      op4(vv[7:4], vv[3:0], vv[8]);
    end
  endtask

  task automatic test_random16();
    for (int i = 0; i < 150; i++)
      op16(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'($urandom_range(0, 1)));
    op16(16'h0000, 16'hFFFF, 1'b1);
    op16(16'hFFFF, 16'hFFFF, 1'b0);
  endtask

  initial begin
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; bin16 = 1'b0;
    test_reset();
    test_basic();
    test_boundary();
    test_reset_mid_run();
    test_start_while_busy();
    test_back_to_back();
    test_exhaustive4();
    test_random16();
    repeat (3) @(posedge clk);
    checks++;
    if (exp4_q.size() != 0 || exp16_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain w4_left=%0d w16_left=%0d exp 0", exp4_q.size(), exp16_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
